// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle IEEE-754 add/subtract, RNE rounding, flush-to-zero, valid/ready handshake
module fp_addsub_seq #(
  parameter int X         = 32,
  parameter int expo_bits = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [X-1:0] a,
  input  logic [X-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [X-1:0] result,
  output logic [3:0]   flags
);
  localparam int E  = expo_bits;
  localparam int F  = X - E - 1;
  localparam int EW = E + 2;
  localparam int MW = F + 5;  // carry, hidden, fraction, guard, round, sticky

  localparam logic [E-1:0]           EXP_ONES = {E{1'b1}};
  localparam logic signed [EW-1:0]   EXP_MAX  = {2'b00, {E{1'b1}}};
  localparam logic signed [EW-1:0]   EXP_ZERO = '0;
  localparam logic signed [EW-1:0]   EXP_ONE  = 1;
  localparam logic [X-1:0]           QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [X-1:0]           a_q, b_q;
  logic                   op_q;
  logic                   sign_q;
  logic                   eff_sub_q;
  logic signed [EW-1:0]   exp_q;
  logic [F+3:0]           big_q, small_q;
  logic [MW-1:0]          mant_q;
  logic [X-1:0]           result_q;
  logic [3:0]             flags_q;

  // Operand classification; sb already carries the op inversion.
  logic         sa, sb;
  logic [E-1:0] ea, eb;
  logic [F-1:0] fa, fb, fa_m, fb_m;
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  always_comb begin
    sa     = a_q[X-1];
    sb     = b_q[X-1] ^ op_q;
    ea     = a_q[X-2:F];
    eb     = b_q[X-2:F];
    fa     = a_q[F-1:0];
    fb     = b_q[F-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_snan = a_nan && !fa[F-1];
    b_snan = b_nan && !fb[F-1];
    fa_m   = a_zero ? '0 : fa;
    fb_m   = b_zero ? '0 : fb;
  end

  // Magnitude ordering and alignment of the smaller significand
  logic [X-2:0]  key_a, key_b;
  logic          swap;
  logic          sign_l;
  logic [E-1:0]  el, es;
  logic [EW-1:0] diff;
  logic [F+3:0]  ext_a, ext_b, ext_l, ext_s, mask_s, shifted_s;

  always_comb begin
    key_a     = a_zero ? '0 : a_q[X-2:0];
    key_b     = b_zero ? '0 : b_q[X-2:0];
    swap      = key_b > key_a;
    sign_l    = swap ? sb : sa;
    el        = swap ? eb : ea;
    es        = swap ? ea : eb;
    ext_a     = {~a_zero, fa_m, 3'b000};
    ext_b     = {~b_zero, fb_m, 3'b000};
    ext_l     = swap ? ext_b : ext_a;
    ext_s     = swap ? ext_a : ext_b;
    diff      = EW'(el) - EW'(es);
    mask_s    = '0;
    shifted_s = '0;
    if (diff > EW'(F + 3)) begin
      shifted_s = {{(F+3){1'b0}}, |ext_s};
    end else begin
      mask_s    = ((F+4)'(1) << diff) - (F+4)'(1);
      shifted_s = (ext_s >> diff) | {{(F+3){1'b0}}, |(ext_s & mask_s)};
    end
  end

  // Special operands bypass the arithmetic pipeline entirely
  logic         is_special;
  logic [X-1:0] spec_res;
  logic [3:0]   spec_flags;

  always_comb begin
    is_special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
    spec_res   = {sa & sb, {(X-1){1'b0}}};
    spec_flags = '0;
    if (a_nan | b_nan) begin
      spec_res   = QNAN;
      spec_flags = {a_snan | b_snan, 3'b000};
    end else if (a_inf & b_inf & (sa != sb)) begin
      spec_res   = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_res = {sa, EXP_ONES, {F{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sb, EXP_ONES, {F{1'b0}}};
    end
  end

  logic [MW-1:0] sum;
  assign sum = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                         : ({1'b0, big_q} + {1'b0, small_q});

  // Round-to-nearest-even and final range check
  logic                 rg, rr, rs, inc;
  logic [F+1:0]         rnd;
  logic signed [EW-1:0] exp_r;
  logic [F-1:0]         frac_r;
  logic [X-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

  always_comb begin
    rg        = mant_q[2];
    rr        = mant_q[1];
    rs        = mant_q[0];
    inc       = rg & (rr | rs | mant_q[3]);
    rnd       = {1'b0, mant_q[F+3:3]} + {{(F+1){1'b0}}, inc};
    exp_r     = exp_q;
    frac_r    = rnd[F-1:0];
    if (rnd[F+1]) begin
      exp_r  = exp_q + EXP_ONE;
      frac_r = rnd[F:1];
    end
    rnd_res   = {sign_q, exp_r[E-1:0], frac_r};
    rnd_flags = {3'b000, rg | rr | rs};
    if (mant_q == '0) begin
      rnd_res   = {sign_q, {(X-1){1'b0}}};
      rnd_flags = '0;
    end else if (exp_r >= EXP_MAX) begin
      rnd_res   = {sign_q, EXP_ONES, {F{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (exp_r <= EXP_ZERO) begin
      rnd_res   = {sign_q, {(X-1){1'b0}}};
      rnd_flags = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_ALIGN;
      S_ALIGN: state_nx = is_special ? S_DONE : S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM:  if (mant_q[MW-1] || mant_q[MW-2] || (mant_q == '0)) state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      big_q     <= '0;
      small_q   <= '0;
      mant_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
          end
        end
        S_ALIGN: begin
          sign_q    <= sign_l;
          eff_sub_q <= sa ^ sb;
          exp_q     <= EW'(el);
          big_q     <= ext_l;
          small_q   <= shifted_s;
          if (is_special) begin
            result_q <= spec_res;
            flags_q  <= spec_flags;
          end
        end
        S_ADD: begin
          mant_q <= sum;
          if (sum == '0) sign_q <= 1'b0;
        end
        S_NORM: begin
          // Carry shifts right once; otherwise walk the leading one up a bit per cycle.
          if (mant_q[MW-1]) begin
            mant_q <= {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXP_ONE;
          end else if (!mant_q[MW-2] && (mant_q != '0)) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        S_ROUND: begin
          result_q <= rnd_res;
          flags_q  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - self-checking bench for fp_addsub_seq (binary32 and binary64 instances)
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  logic        in_valid_w, in_ready_w, op_w, out_valid_w, out_ready_w;
  logic [63:0] a_w, b_w, result_w;
  logic [3:0]  flags_w;

  int total = 0;
  int bad   = 0;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_addsub_seq #(.X(64), .expo_bits(11)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .op(op_w),
    .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w), .flags(flags_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'd0) d = {v[31], 63'd0};
    else d = {v[31], 11'(v[30:23]) - 11'd127 + 11'd1023, v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: exact-enough double sum, then RNE to 24 bits with flush/overflow rules.
  function automatic logic [35:0] model(input logic [31:0] xa, input logic [31:0] xb, input logic xop);
    logic [31:0] bb;
    logic        an, bn, as_, bs_, ai, bi, sgn, up, inexact;
    real         da, db, s, err, ada, adb;
    logic [63:0] sbits;
    logic [52:0] m;
    logic [23:0] keep;
    logic [24:0] keep25;
    logic [28:0] rem;
    int          e;
    bb  = xb ^ {xop, 31'd0};
    an  = (xa[30:23] == 8'hFF) && (xa[22:0] != 0);
    bn  = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
    as_ = an && !xa[22];
    bs_ = bn && !bb[22];
    ai  = (xa[30:23] == 8'hFF) && (xa[22:0] == 0);
    bi  = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
    if (an || bn) return {32'h7FC00000, as_ | bs_, 3'b000};
    if (ai && bi && (xa[31] != bb[31])) return {32'h7FC00000, 4'b1000};
    if (ai) return {xa, 4'b0000};
    if (bi) return {bb, 4'b0000};
    da  = f2r(xa);
    db  = f2r(bb);
    s   = da + db;
    ada = (da < 0.0) ? -da : da;
    adb = (db < 0.0) ? -db : db;
    if (ada >= adb) err = db - (s - da);
    else            err = da - (s - db);
    sbits = $realtobits(s);
    sgn   = sbits[63];
    if (s == 0.0) return {sgn, 31'd0, 4'b0000};
    e      = int'(sbits[62:52]) - 896;
    m      = {1'b1, sbits[51:0]};
    keep   = m[52:29];
    rem    = m[28:0];
    up     = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    keep25 = {1'b0, keep} + 25'(up);
    if (keep25[24]) begin
      e++;
      keep = keep25[24:1];
    end else begin
      keep = keep25[23:0];
    end
    inexact = (rem != 0) || (err != 0.0);
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)   return {sgn, 31'd0, 4'b0011};
    return {sgn, e[7:0], keep[22:0], 3'b000, inexact};
  endfunction

  function automatic logic [31:0] gen_f(input int base_e);
    logic [31:0] r;
    int          e;
    int          sel;
    r   = $urandom;
    sel = int'($urandom_range(0, 19));
    if (sel == 0)      e = 0;
    else if (sel == 1) e = 255;
    else if (sel == 2) e = 254;
    else begin
      e = base_e + int'($urandom_range(0, 50)) - 25;
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
    end
    if ((sel == 1 && r[1]) || sel == 3) r[22:0] = '0;
    return {r[31], e[7:0], r[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    int n;
    @(negedge clk);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      if (!out_valid) lat++;
      n++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    r = result;
    f = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_op64(input logic [63:0] xa, input logic [63:0] xb, input logic xop,
                         output logic [63:0] r, output logic [3:0] f);
    int n;
    @(negedge clk);
    a_w = xa; b_w = xb; op_w = xop; in_valid_w = 1'b1;
    @(posedge clk);
    #1 in_valid_w = 1'b0;
    n = 0;
    while (!out_valid_w && n < 100) begin @(negedge clk); n++; end
    check("w_out_valid_seen", 64'(out_valid_w), 64'd1);
    r = result_w;
    f = flags_w;
    out_ready_w = 1'b1;
    @(posedge clk);
    #1 out_ready_w = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [63:0] rw;
    logic [35:0] expv;
    logic [31:0] xa, xb;
    logic [31:0] rbits;
    int          lat, n, be;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; op_w = 1'b0; a_w = '0; b_w = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_w_in_ready", 64'(in_ready_w), 64'd1);
    check("rst_w_result", result_w, 64'd0);
    rst_n = 1'b1;

    do_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
    check("one_plus_two", 64'(r), 64'h40400000);
    check("one_plus_two_flags", 64'(f), 64'd0);
    check("one_plus_two_lat", 64'(lat), 64'd5);

    do_op(32'h3F800000, 32'h3F400000, 1'b1, r, f, lat);
    check("sub_k2", 64'(r), 64'h3E800000);
    check("sub_k2_flags", 64'(f), 64'd0);
    check("sub_k2_lat", 64'(lat), 64'd7);

    do_op(32'h3F800000, 32'h33800000, 1'b0, r, f, lat);
    check("tie_even", 64'({r, f}), 64'({32'h3F800000, 4'b0001}));
    do_op(32'h3F800001, 32'h33800000, 1'b0, r, f, lat);
    check("tie_odd", 64'({r, f}), 64'({32'h3F800002, 4'b0001}));

    do_op(32'h7F800000, 32'hFF800000, 1'b0, r, f, lat);
    check("inf_minus_inf", 64'({r, f}), 64'({32'h7FC00000, 4'b1000}));
    check("inf_minus_inf_lat", 64'(lat), 64'd2);

    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, f, lat);
    check("overflow", 64'({r, f}), 64'({32'h7F800000, 4'b0101}));

    // Backpressure: result held while the consumer stalls.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", 64'(result), 64'h40400000);
      check("hold_flags", 64'(flags), 64'd0);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);

    // Reset while normalising: outputs clear at once, the operation is dropped.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F400000; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_output", 64'(out_valid), 64'd0);
    do_op(32'h3F800000, 32'h3F400000, 1'b1, r, f, lat);
    check("after_rst", 64'({r, f}), 64'({32'h3E800000, 4'b0000}));
    check("after_rst_lat", 64'(lat), 64'd7);

    for (int i = 0; i < 300; i++) begin
      be = int'($urandom_range(1, 254));
      xa = gen_f(be);
      xb = ($urandom_range(0, 7) == 0) ? xa : gen_f(be);
      rbits = $urandom;
      expv  = model(xa, xb, rbits[0]);
      do_op(xa, xb, rbits[0], r, f, lat);
      check("random", 64'({r, f}), 64'(expv));
    end

    do_op64(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, rw, f);
    check("w_one_plus_one", rw, 64'h4000000000000000);
    check("w_one_plus_one_flags", 64'(f), 64'd0);
    do_op64(64'h4000000000000000, 64'h4000000000000000, 1'b1, rw, f);
    check("w_two_minus_two", rw, 64'h0000000000000000);
    check("w_two_minus_two_flags", 64'(f), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
